// File: rtl/mesi_isc_cache_agent_if.sv
// Bundles the three handshakes of one cache agent: the CPU request port, the
// main bus (agent is initiator) and the coherence bus (agent is responder).
interface mesi_isc_cache_agent_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3
);
    logic                      cpu_req_i;
    logic                      cpu_wr_i;
    logic [ADDR_WIDTH-1:0]     cpu_addr_i;
    logic                      cpu_ack_o;
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o;
    logic [ADDR_WIDTH-1:0]     mbus_addr_o;
    logic                      mbus_ack_i;
    logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i;
    logic [ADDR_WIDTH-1:0]     cbus_addr_i;
    logic                      cbus_ack_o;

    // Agent side.
    modport slave (
        input  cpu_req_i, cpu_wr_i, cpu_addr_i,
        output cpu_ack_o,
        output mbus_cmd_o, mbus_addr_o,
        input  mbus_ack_i,
        input  cbus_cmd_i, cbus_addr_i,
        output cbus_ack_o
    );

    // CPU / controller side.
    modport master (
        output cpu_req_i, cpu_wr_i, cpu_addr_i,
        input  cpu_ack_o,
        input  mbus_cmd_o, mbus_addr_o,
        output mbus_ack_i,
        output cbus_cmd_i, cbus_addr_i,
        input  cbus_ack_o
    );
endinterface

// File: rtl/mesi_isc_cache_agent.sv
// Cache-side endpoint for one CPU port of the MESI coherence controller.
// Keeps a small direct-mapped MESI table, issues broadcasts / memory traffic
// on the main bus and services snoops and enables on the coherence bus.
module mesi_isc_cache_agent #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int LINES_LOG2     = 2
) (
    input logic                   clk,
    input logic                   rst,
    mesi_isc_cache_agent_if.slave bus
);
    localparam int LINES = 1 << LINES_LOG2;

    localparam logic [MBUS_CMD_WIDTH-1:0] MB_NOP      = MBUS_CMD_WIDTH'(0);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR       = MBUS_CMD_WIDTH'(1);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD       = MBUS_CMD_WIDTH'(2);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR_BROAD = MBUS_CMD_WIDTH'(3);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD_BROAD = MBUS_CMD_WIDTH'(4);

    localparam logic [CBUS_CMD_WIDTH-1:0] CB_NOP      = CBUS_CMD_WIDTH'(0);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_RD    = CBUS_CMD_WIDTH'(4);

    typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3} mesi_e;
    typedef enum logic [2:0] {IDLE, EVICT, BROAD, WAIT_EN, MEM, SNP_WB, SNP_ACK} fsm_e;

    mesi_e                     state_q [LINES];
    logic [ADDR_WIDTH-1:0]     tag_q   [LINES];

    fsm_e                      fsm_q, fsm_d, ret_q, ret_d;
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_q, mbus_cmd_d;
    logic [ADDR_WIDTH-1:0]     mbus_addr_q, mbus_addr_d;
    logic                      cpu_ack_q, cpu_ack_d;
    logic                      cbus_ack_q, cbus_ack_d;
    logic                      req_wr_q, req_wr_d;
    logic [ADDR_WIDTH-1:0]     req_addr_q, req_addr_d;
    logic [CBUS_CMD_WIDTH-1:0] snp_cmd_q, snp_cmd_d;
    logic [ADDR_WIDTH-1:0]     snp_addr_q, snp_addr_d;
    logic                      blk_q, blk_set;
    logic [CBUS_CMD_WIDTH-1:0] blk_cmd_q;
    logic [ADDR_WIDTH-1:0]     blk_addr_q;

    logic                      tbl_we;
    logic [LINES_LOG2-1:0]     tbl_idx;
    mesi_e                     tbl_state_w;
    logic [ADDR_WIDTH-1:0]     tbl_tag_w;

    logic [LINES_LOG2-1:0]     cpu_idx, req_idx, snp_idx, hsnp_idx;
    logic                      cpu_hit, cpu_local, snp_hit, snp_vld, cb_blocked, en_ok;

    assign cpu_idx  = bus.cpu_addr_i[LINES_LOG2-1:0];
    assign req_idx  = req_addr_q[LINES_LOG2-1:0];
    assign snp_idx  = bus.cbus_addr_i[LINES_LOG2-1:0];
    assign hsnp_idx = snp_addr_q[LINES_LOG2-1:0];

    assign cpu_hit   = (tag_q[cpu_idx] == bus.cpu_addr_i) && (state_q[cpu_idx] != ST_I);
    assign cpu_local = cpu_hit && (!bus.cpu_wr_i || state_q[cpu_idx] == ST_E ||
                                   state_q[cpu_idx] == ST_M);
    assign snp_hit   = (tag_q[snp_idx] == bus.cbus_addr_i) && (state_q[snp_idx] != ST_I);

    // A command already acked stays invisible until the bus goes NOP or moves address.
    assign cb_blocked = blk_q && (bus.cbus_cmd_i == blk_cmd_q) && (bus.cbus_addr_i == blk_addr_q);
    assign snp_vld    = !cb_blocked && (bus.cbus_cmd_i == CB_WR_SNOOP || bus.cbus_cmd_i == CB_RD_SNOOP);
    assign en_ok      = !cb_blocked && (bus.cbus_addr_i == req_addr_q) &&
                        (bus.cbus_cmd_i == (req_wr_q ? CB_EN_WR : CB_EN_RD));

    assign bus.mbus_cmd_o  = mbus_cmd_q;
    assign bus.mbus_addr_o = mbus_addr_q;
    assign bus.cpu_ack_o   = cpu_ack_q;
    assign bus.cbus_ack_o  = cbus_ack_q;

    // MESI state table: one write port driven by the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LINES; i++) begin
                state_q[i] <= ST_I;
                tag_q[i]   <= '0;
            end
        end else if (tbl_we) begin
            state_q[tbl_idx] <= tbl_state_w;
            tag_q[tbl_idx]   <= tbl_tag_w;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= IDLE;
            ret_q       <= IDLE;
            mbus_cmd_q  <= MB_NOP;
            mbus_addr_q <= '0;
            cpu_ack_q   <= 1'b0;
            cbus_ack_q  <= 1'b0;
            blk_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            ret_q       <= ret_d;
            mbus_cmd_q  <= mbus_cmd_d;
            mbus_addr_q <= mbus_addr_d;
            cpu_ack_q   <= cpu_ack_d;
            cbus_ack_q  <= cbus_ack_d;
            if (blk_set)
                blk_q <= 1'b1;
            else if (bus.cbus_cmd_i == CB_NOP || bus.cbus_addr_i != blk_addr_q)
                blk_q <= 1'b0;
        end
    end

    // Captured request / snoop details; only meaningful while the FSM uses them.
    always_ff @(posedge clk) begin
        req_wr_q   <= req_wr_d;
        req_addr_q <= req_addr_d;
        snp_cmd_q  <= snp_cmd_d;
        snp_addr_q <= snp_addr_d;
        if (blk_set) begin
            blk_cmd_q  <= bus.cbus_cmd_i;
            blk_addr_q <= bus.cbus_addr_i;
        end
    end

    // Next-state logic; each bus state issues its command on entry and leaves on ack.
    always_comb begin
        fsm_d       = fsm_q;
        ret_d       = ret_q;
        mbus_cmd_d  = mbus_cmd_q;
        mbus_addr_d = mbus_addr_q;
        cpu_ack_d   = 1'b0;
        cbus_ack_d  = 1'b0;
        blk_set     = 1'b0;
        req_wr_d    = req_wr_q;
        req_addr_d  = req_addr_q;
        snp_cmd_d   = snp_cmd_q;
        snp_addr_d  = snp_addr_q;
        tbl_we      = 1'b0;
        tbl_idx     = req_idx;
        tbl_state_w = ST_I;
        tbl_tag_w   = req_addr_q;

        if ((fsm_q == IDLE || fsm_q == WAIT_EN) && snp_vld) begin
            snp_cmd_d  = bus.cbus_cmd_i;
            snp_addr_d = bus.cbus_addr_i;
            blk_set    = 1'b1;
            ret_d      = fsm_q;
            if (snp_hit && state_q[snp_idx] == ST_M) begin
                fsm_d = SNP_WB;
            end else begin
                fsm_d      = SNP_ACK;
                cbus_ack_d = 1'b1;
                if (snp_hit) begin
                    tbl_we    = 1'b1;
                    tbl_idx   = snp_idx;
                    tbl_tag_w = bus.cbus_addr_i;
                    if (bus.cbus_cmd_i == CB_WR_SNOOP) tbl_state_w = ST_I;
                    else                               tbl_state_w = ST_S;
                end
            end
        end else begin
            case (fsm_q)
                IDLE: begin
                    // The ack cycle still sees the old request; ignore it then.
                    if (bus.cpu_req_i && !cpu_ack_q) begin
                        req_wr_d   = bus.cpu_wr_i;
                        req_addr_d = bus.cpu_addr_i;
                        if (cpu_local) begin
                            cpu_ack_d = 1'b1;
                            if (bus.cpu_wr_i) begin
                                tbl_we      = 1'b1;
                                tbl_idx     = cpu_idx;
                                tbl_tag_w   = bus.cpu_addr_i;
                                tbl_state_w = ST_M;
                            end
                        end else if (state_q[cpu_idx] == ST_M && tag_q[cpu_idx] != bus.cpu_addr_i) begin
                            fsm_d = EVICT;
                        end else begin
                            fsm_d = BROAD;
                        end
                    end
                end
                EVICT: begin
                    if (mbus_cmd_q == MB_NOP) begin
                        mbus_cmd_d  = MB_WR;
                        mbus_addr_d = tag_q[req_idx];
                    end else if (bus.mbus_ack_i) begin
                        mbus_cmd_d  = MB_NOP;
                        tbl_we      = 1'b1;
                        tbl_tag_w   = tag_q[req_idx];
                        tbl_state_w = ST_I;
                        fsm_d       = BROAD;
                    end
                end
                BROAD: begin
                    if (mbus_cmd_q == MB_NOP) begin
                        mbus_cmd_d  = req_wr_q ? MB_WR_BROAD : MB_RD_BROAD;
                        mbus_addr_d = req_addr_q;
                    end else if (bus.mbus_ack_i) begin
                        mbus_cmd_d = MB_NOP;
                        fsm_d      = WAIT_EN;
                    end
                end
                WAIT_EN: begin
                    if (en_ok) begin
                        cbus_ack_d = 1'b1;
                        blk_set    = 1'b1;
                        fsm_d      = MEM;
                    end
                end
                MEM: begin
                    if (mbus_cmd_q == MB_NOP) begin
                        mbus_cmd_d  = req_wr_q ? MB_WR : MB_RD;
                        mbus_addr_d = req_addr_q;
                    end else if (bus.mbus_ack_i) begin
                        mbus_cmd_d  = MB_NOP;
                        tbl_we      = 1'b1;
                        tbl_state_w = req_wr_q ? ST_M : ST_S;
                        cpu_ack_d   = 1'b1;
                        fsm_d       = IDLE;
                    end
                end
                SNP_WB: begin
                    if (mbus_cmd_q == MB_NOP) begin
                        mbus_cmd_d  = MB_WR;
                        mbus_addr_d = snp_addr_q;
                    end else if (bus.mbus_ack_i) begin
                        mbus_cmd_d  = MB_NOP;
                        tbl_we      = 1'b1;
                        tbl_idx     = hsnp_idx;
                        tbl_tag_w   = snp_addr_q;
                        tbl_state_w = (snp_cmd_q == CB_WR_SNOOP) ? ST_I : ST_S;
                        cbus_ack_d  = 1'b1;
                        fsm_d       = SNP_ACK;
                    end
                end
                SNP_ACK: fsm_d = ret_q;
                default: fsm_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mesi_isc_cache_agent.sv
// Directed bench for the cache agent: a background controller acks main bus
// commands, stimulus pushes the expected event stream, a monitor pops it.
module tb_mesi_isc_cache_agent;
    localparam logic [2:0] M_WR = 3'd1, M_RD = 3'd2, M_WB = 3'd3, M_RB = 3'd4;
    localparam logic [2:0] C_WS = 3'd1, C_RS = 3'd2, C_EW = 3'd3, C_ER = 3'd4;
    localparam int EV_MB = 0, EV_CB = 1, EV_CPU = 2;
    localparam int TMO = 200;

    typedef struct {
        int          kind;
        logic [2:0]  cmd;
        logic [31:0] addr;
    } exp_t;

    logic clk, rst;
    int   checks = 0, errors = 0;
    bit   auto_ack = 1'b1;
    exp_t exp_q[$];

    mesi_isc_cache_agent_if #(.ADDR_WIDTH(32), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3)) bus ();

    mesi_isc_cache_agent #(.ADDR_WIDTH(32), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3), .LINES_LOG2(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic void push_ev(input int kind, input logic [2:0] cmd, input logic [31:0] addr);
        exp_t e;
        e.kind = kind; e.cmd = cmd; e.addr = addr;
        exp_q.push_back(e);
    endfunction

    task automatic check_ev(input int kind, input logic [2:0] cmd, input logic [31:0] addr);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d cmd=%0d addr=%h, expected none", kind, cmd, addr);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_MB && (e.cmd != cmd || e.addr != addr))) begin
                errors++;
                $display("FAIL event_order: got kind=%0d cmd=%0d addr=%h, expected kind=%0d cmd=%0d addr=%h",
                         kind, cmd, addr, e.kind, e.cmd, e.addr);
            end
        end
    endtask

    // Controller model: ack any main bus command on its third cycle.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.mbus_ack_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.mbus_ack_i = 1'b0;
            if (bus.mbus_cmd_o != 3'd0 && auto_ack) begin
                if (wcnt == 2) begin
                    bus.mbus_ack_i = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: protocol checks on mbus plus scoreboard pops for every output event.
    initial begin
        logic [2:0]  pcmd;
        logic [31:0] paddr;
        logic        pack;
        pcmd = '0; paddr = '0; pack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pcmd = '0; pack = 1'b0;
            end else begin
                if (pcmd != 3'd0 && !pack) begin
                    checks++;
                    if (bus.mbus_cmd_o != pcmd || bus.mbus_addr_o != paddr) begin
                        errors++;
                        $display("FAIL mbus_hold: got cmd=%0d addr=%h, required cmd=%0d addr=%h",
                                 bus.mbus_cmd_o, bus.mbus_addr_o, pcmd, paddr);
                    end
                end
                if (pack) begin
                    checks++;
                    if (bus.mbus_cmd_o != 3'd0) begin
                        errors++;
                        $display("FAIL mbus_nop_after_ack: got cmd=%0d, required 0", bus.mbus_cmd_o);
                    end
                end
                if (bus.mbus_cmd_o != 3'd0 && pcmd == 3'd0)
                    check_ev(EV_MB, bus.mbus_cmd_o, bus.mbus_addr_o);
                if (bus.cbus_ack_o) check_ev(EV_CB, 3'd0, 32'd0);
                if (bus.cpu_ack_o)  check_ev(EV_CPU, 3'd0, 32'd0);
                pcmd  = bus.mbus_cmd_o;
                paddr = bus.mbus_addr_o;
                pack  = bus.mbus_ack_i;
            end
        end
    end

    task automatic cpu_op(input logic wr, input logic [31:0] addr, output int lat);
        bus.cpu_req_i = 1'b1; bus.cpu_wr_i = wr; bus.cpu_addr_i = addr;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.cpu_ack_o && lat < TMO);
        if (!bus.cpu_ack_o) begin
            checks++; errors++;
            $display("FAIL cpu_ack_timeout: addr=%h got no ack, required ack", addr);
        end
        bus.cpu_req_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cbus_send(input logic [2:0] cmd, input logic [31:0] addr, output int lat);
        bus.cbus_cmd_i = cmd; bus.cbus_addr_i = addr;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.cbus_ack_o && lat < TMO);
        if (!bus.cbus_ack_o) begin
            checks++; errors++;
            $display("FAIL cbus_ack_timeout: cmd=%0d addr=%h got no ack, required ack", cmd, addr);
        end
        bus.cbus_cmd_i = 3'd0;
        @(posedge clk); #1;
    endtask

    task automatic cbus_noack(input logic [2:0] cmd, input logic [31:0] addr, input int n);
        bus.cbus_cmd_i = cmd; bus.cbus_addr_i = addr;
        repeat (n) begin @(posedge clk); #1; end
        bus.cbus_cmd_i = 3'd0;
        @(posedge clk); #1;
    endtask

    task automatic wait_bcast();
        int n;
        n = 0;
        while (!(bus.mbus_ack_i && (bus.mbus_cmd_o == M_WB || bus.mbus_cmd_o == M_RB)) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            checks++; errors++;
            $display("FAIL bcast_timeout: got no broadcast ack, required one");
        end
        @(posedge clk); #1;
    endtask

    task automatic cpu_miss(input logic wr, input logic [31:0] addr);
        int l1, l2;
        fork
            cpu_op(wr, addr, l1);
            begin
                wait_bcast();
                cbus_send(wr ? C_EW : C_ER, addr, l2);
            end
        join
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    initial begin
        int lat, n;
        rst = 1'b0;
        bus.cpu_req_i = 1'b0; bus.cpu_wr_i = 1'b0; bus.cpu_addr_i = '0;
        bus.cbus_cmd_i = '0; bus.cbus_addr_i = '0;
        repeat (3) @(negedge clk);
        check_val("rst_mbus_cmd",  32'(bus.mbus_cmd_o), 32'd0);
        check_val("rst_mbus_addr", bus.mbus_addr_o, 32'd0);
        check_val("rst_cpu_ack",   32'(bus.cpu_ack_o), 32'd0);
        check_val("rst_cbus_ack",  32'(bus.cbus_ack_o), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Read miss 0x10 -> line S.
        push_ev(EV_MB, M_RB, 32'h10); push_ev(EV_CB, 0, 0); push_ev(EV_MB, M_RD, 32'h10); push_ev(EV_CPU, 0, 0);
        cpu_miss(1'b0, 32'h10);

        // Write to S line needs a broadcast; then a write hit in M is local.
        push_ev(EV_MB, M_WB, 32'h10); push_ev(EV_CB, 0, 0); push_ev(EV_MB, M_WR, 32'h10); push_ev(EV_CPU, 0, 0);
        cpu_miss(1'b1, 32'h10);
        push_ev(EV_CPU, 0, 0);
        cpu_op(1'b1, 32'h10, lat);
        check_val("write_hit_latency", lat, 32'd1);

        // WR_SNOOP on M line: write-back then ack; line becomes I.
        push_ev(EV_MB, M_WR, 32'h10); push_ev(EV_CB, 0, 0);
        cbus_send(C_WS, 32'h10, lat);
        push_ev(EV_CB, 0, 0);
        cbus_send(C_RS, 32'h10, lat);
        check_val("rd_snoop_on_I_latency", lat, 32'd1);

        // Make 0x10 M again, then a write to 0x14 evicts it.
        push_ev(EV_MB, M_WB, 32'h10); push_ev(EV_CB, 0, 0); push_ev(EV_MB, M_WR, 32'h10); push_ev(EV_CPU, 0, 0);
        cpu_miss(1'b1, 32'h10);
        push_ev(EV_MB, M_WR, 32'h10); push_ev(EV_MB, M_WB, 32'h14); push_ev(EV_CB, 0, 0);
        push_ev(EV_MB, M_WR, 32'h14); push_ev(EV_CPU, 0, 0);
        cpu_miss(1'b1, 32'h14);

        // Write 0x7 with a snoop and bad enables arriving during WAIT_EN.
        push_ev(EV_MB, M_WB, 32'h7); push_ev(EV_CB, 0, 0); push_ev(EV_CB, 0, 0);
        push_ev(EV_MB, M_WR, 32'h7); push_ev(EV_CPU, 0, 0);
        fork
            cpu_op(1'b1, 32'h7, n);
            begin
                wait_bcast();
                cbus_send(C_RS, 32'h8, lat);
                cbus_noack(C_ER, 32'h7, 4);
                cbus_noack(C_EW, 32'h9, 4);
                cbus_send(C_EW, 32'h7, lat);
            end
        join

        // RD_SNOOP on M line 0x14: write-back, line S; a read then hits locally.
        push_ev(EV_MB, M_WR, 32'h14); push_ev(EV_CB, 0, 0);
        cbus_send(C_RS, 32'h14, lat);
        push_ev(EV_CPU, 0, 0);
        cpu_op(1'b0, 32'h14, lat);
        check_val("read_hit_S_latency", lat, 32'd1);

        // Reset in the middle of MEM.
        push_ev(EV_MB, M_WB, 32'h20); push_ev(EV_CB, 0, 0); push_ev(EV_MB, M_WR, 32'h20);
        bus.cpu_req_i = 1'b1; bus.cpu_wr_i = 1'b1; bus.cpu_addr_i = 32'h20;
        wait_bcast();
        cbus_send(C_EW, 32'h20, lat);
        auto_ack = 1'b0;
        n = 0;
        while (bus.mbus_cmd_o != M_WR && n < TMO) begin @(posedge clk); #1; n++; end
        check_val("mem_wr_seen", 32'(bus.mbus_cmd_o), 32'(M_WR));
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check_val("midrst_mbus_cmd",  32'(bus.mbus_cmd_o), 32'd0);
        check_val("midrst_mbus_addr", bus.mbus_addr_o, 32'd0);
        check_val("midrst_cpu_ack",   32'(bus.cpu_ack_o), 32'd0);
        check_val("midrst_cbus_ack",  32'(bus.cbus_ack_o), 32'd0);
        bus.cpu_req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        auto_ack = 1'b1;
        repeat (10) begin @(posedge clk); #1; end

        // Table was cleared: 0x14 misses again.
        push_ev(EV_MB, M_RB, 32'h14); push_ev(EV_CB, 0, 0); push_ev(EV_MB, M_RD, 32'h14); push_ev(EV_CPU, 0, 0);
        cpu_miss(1'b0, 32'h14);

        repeat (5) begin @(posedge clk); #1; end
        check_val("events_left", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
